button_event_queue: RTL and testbench

Memory-mapped input peripheral that turns the four raw push-buttons into a queue of discrete press events the processor consumes by load. It synchronizes and debounces BTNU/BTNR/BTND/BTNL, detects press (rising) edges, arbitrates simultaneous presses and buffers the events in a small FIFO. It sits in the top-level wrapper beside the LED output register: the wrapper decodes a dmem read of the button address into `pop` and muxes `data_out` onto `q_dmem`.

---
 rtl/button_event_queue.sv | 169 ++++++++++++++++
 tb/tb_button_event_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_queue.sv
// Push-button event queue: synchronizes and debounces four buttons, turns presses
// into event codes and buffers them in a small FIFO that the CPU drains by load.
module button_event_queue #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DEPTH           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        BTNU,
  input  logic        BTNR,
  input  logic        BTND,
  input  logic        BTNL,
  input  logic        pop,
  output logic [31:0] data_out,
  output logic        empty,
  output logic        full
);

  localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int                PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [3:0]        DEPTH_CNT = 4'(DEPTH);

  typedef enum logic [2:0] {
    EV_NONE = 3'd0,
    EV_U    = 3'd1,
    EV_R    = 3'd2,
    EV_D    = 3'd3,
    EV_L    = 3'd4
  } ev_code_t;

  // Bit i of every per-button vector: 0 = U, 1 = R, 2 = D, 3 = L (priority order).
  logic [3:0]       raw;
  logic [3:0]       sync_a;
  logic [3:0]       sync_s;
  logic [3:0]       db;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       accept;
  logic [3:0]       rise;
  logic [3:0]       pending;
  logic [3:0]       grant;
  ev_code_t         push_code;

  ev_code_t         mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [3:0]       count;
  logic             overflow;
  logic             push;
  logic             pop_ok;
  logic             push_ok;
  logic             drop;
  ev_code_t         head_code;

  assign raw = {BTNL, BTND, BTNR, BTNU};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_s <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so both flops sample
      // the pre-edge values and form a real two-stage chain.
      sync_a <= raw;
      sync_s <= sync_a;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    accept = '0;
    for (int i = 0; i < 4; i++) begin
      accept[i] = (sync_s[i] != db[i]) && (cnt[i] == CNT_LAST);
    end
    rise = accept & sync_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_s[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          db[i]  <= sync_s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Fixed priority: the lowest-numbered pending button wins the single push slot.
  always_comb begin
    grant     = '0;
    push_code = EV_NONE;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        push_code = ev_code_t'(3'(i + 1));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~grant) | rise;
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == 4'd0);
  assign full    = (count == DEPTH_CNT);
  assign push    = |pending;
  assign pop_ok  = pop && !empty;
  // A full queue still accepts a push when the same edge frees a slot.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  // NOTE: the storage array has no reset; count and pointers alone define which
  // entries are valid, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (pop_ok) begin
        overflow <= 1'b0;
      end
    end
  end

  assign head_code = empty ? EV_NONE : mem[rd_ptr];
  assign data_out  = {23'b0, overflow, count, 1'b0, head_code};

endmodule

// File: tb/tb_button_event_queue.sv
// Bench for button_event_queue: a sampled-window debounce model with an event
// queue is compared every cycle, plus directed literal checks from hand timing.
module tb_button_event_queue;

  localparam int DB    = 4;
  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic [3:0]  btn;
  logic        pop;
  logic [31:0] data_out;
  logic        empty;
  logic        full;

  int n_checks;
  int n_fail;

  button_event_queue #(.DEBOUNCE_CYCLES(DB), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .BTNU     (btn[0]),
    .BTNR     (btn[1]),
    .BTND     (btn[2]),
    .BTNL     (btn[3]),
    .pop      (pop),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a button's level flips once its synchronized samples over the last DB
  // edges all disagree with it; presses queue up, one per edge, U first.
  logic [2:0] m_q [$];
  logic [3:0] m_hist [$];
  logic [3:0] m_db;
  logic [3:0] m_pend;
  logic       m_ovf;
  int         m_idx;
  logic       m_popok;
  logic       m_wasfull;
  logic       m_flip;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_hist.delete();
      for (int k = 0; k < DB + 1; k++) m_hist.push_back(4'b0);
      m_db   = '0;
      m_pend = '0;
      m_ovf  = 1'b0;
    end else begin
      m_idx = -1;
      for (int i = 0; i < 4; i++) begin
        if (m_pend[i] && m_idx < 0) m_idx = i;
      end
      m_popok   = pop && (m_q.size() > 0);
      m_wasfull = (m_q.size() == DEPTH);
      if (m_popok) void'(m_q.pop_front());
      if (m_idx >= 0) begin
        if (!m_wasfull || m_popok) m_q.push_back(3'(m_idx + 1));
        else m_ovf = 1'b1;
        m_pend[m_idx] = 1'b0;
      end
      if (m_popok && !(m_idx >= 0 && m_wasfull && !m_popok) && !(m_idx >= 0 && m_wasfull && m_popok && 0))
        if (!(m_idx >= 0 && m_wasfull && !m_popok)) m_ovf = 1'b0;
      // synchronized sample seen at edge n is the raw level two edges earlier
      for (int i = 0; i < 4; i++) begin
        m_flip = 1'b1;
        for (int k = 0; k < DB; k++) begin
          if (m_hist[k][i] == m_db[i]) m_flip = 1'b0;
        end
        if (m_flip) begin
          m_db[i] = ~m_db[i];
          if (m_db[i]) m_pend[i] = 1'b1;
        end
      end
      m_hist.push_back(btn);
      void'(m_hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("model data_out", data_out,
            {23'b0, m_ovf, 4'(m_q.size()), 1'b0, (m_q.size() > 0) ? m_q[0] : 3'b0});
      check("model empty/full", {30'b0, empty, full},
            {30'b0, m_q.size() == 0, m_q.size() == DEPTH});
    end
  end

  task automatic press(input int b);
    @(negedge clk);
    btn[b] = 1'b1;
    repeat (8) @(negedge clk);
    btn[b] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic pop_pulse();
    @(negedge clk);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    btn      = '0;
    pop      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset data_out", data_out, 32'h0);
    check("reset empty/full", {30'b0, empty, full}, 32'h2);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single press: R raised before edge 0, visible only after edge 6.
    btn[1] = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 check("single before edge 6", data_out, 32'h0);
    @(posedge clk);
    #1 check("single after edge 6", data_out, 32'h12);
    @(negedge clk);
    btn[1] = 1'b0;
    pop_pulse();
    check("single popped", data_out, 32'h0);
    check("single empty", {31'b0, empty}, 32'h1);
    repeat (8) @(negedge clk);

    // Bounce shorter than the debounce window never produces an event.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      btn[0] = ((k / 2) % 2) == 0;
    end
    @(negedge clk);
    btn[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce no event", data_out, 32'h0);
    btn[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("bounce then held", data_out, 32'h11);
    btn[0] = 1'b0;
    pop_pulse();
    repeat (8) @(negedge clk);

    // Simultaneous press of all four.
    btn = 4'b1111;
    repeat (12) @(negedge clk);
    begin
      logic [31:0] exp_sim [4];
      exp_sim[0] = 32'h41; exp_sim[1] = 32'h32; exp_sim[2] = 32'h23; exp_sim[3] = 32'h14;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("simultaneous pop order", data_out, exp_sim[k]);
        pop = 1'b1;
      end
    end
    @(negedge clk);
    pop = 1'b0;
    check("simultaneous drained", data_out, 32'h0);
    btn = 4'b0000;
    repeat (10) @(negedge clk);

    // Nine presses without pops: U R D L U R D L U, the last one dropped.
    for (int k = 0; k < 9; k++) press(k % 4);
    check("full overflow", data_out, 32'h181);
    check("full flag", {31'b0, full}, 32'h1);
    pop_pulse();
    check("pop clears overflow", data_out, 32'h72);
    press(1);
    check("refilled", data_out, 32'h82);
    // D raised before edge E0; its push lands at E0+6 together with a pop.
    @(negedge clk);
    btn[2] = 1'b1;
    repeat (6) @(negedge clk);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    check("push+pop while full", data_out, 32'h83);
    repeat (2) @(negedge clk);
    btn[2] = 1'b0;
    repeat (8) @(negedge clk);
    pop = 1'b1;
    repeat (8) @(negedge clk);
    pop = 1'b0;
    check("drained after full", data_out, 32'h0);

    // Interleaved presses and pops across pointer wrap.
    for (int k = 0; k < 20; k++) begin
      press(k % 4);
      check("wrap head", data_out, 32'h10 | 32'(k % 4 + 1));
      pop_pulse();
    end
    pop_pulse();
    check("pop while empty", data_out, 32'h0);
    check("empty after empty pop", {31'b0, empty}, 32'h1);

    // Reset mid-cycle with three entries queued and buttons still held.
    @(negedge clk);
    btn = 4'b0111;
    repeat (12) @(negedge clk);
    check("three queued", data_out, 32'h31);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("async reset data_out", data_out, 32'h0);
    check("async reset empty/full", {30'b0, empty, full}, 32'h2);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("post-reset still debouncing", data_out, 32'h0);
    @(posedge clk);
    #1 check("post-reset U event", data_out, 32'h11);
    @(negedge clk);
    btn = 4'b0000;
    repeat (4) @(negedge clk);
    check("post-reset queued", data_out, 32'h31);
    pop = 1'b1;
    repeat (3) @(negedge clk);
    pop = 1'b0;
    repeat (8) @(negedge clk);
    check("final empty", data_out, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
